// File: rtl/qcore_reg_wr_arb.sv
// Register-bank write arbiter: the core, three secondary writers and the wave loader
// share one registered bank write port. A starvation guard forces core stalls.
module qcore_reg_wr_arb #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             core_we_i,
    input  logic [6:0]       core_addr_i,
    input  logic [31:0]      core_dt_i,
    output logic             core_stall_o,
    input  logic [2:0]       req_vld_i,
    input  logic [2:0][6:0]  req_addr_i,
    input  logic [2:0][31:0] req_dt_i,
    output logic [2:0]       req_rdy_o,
    input  logic             wave_vld_i,
    input  logic [167:0]     wave_dt_i,
    output logic             wave_rdy_o,
    output logic             we_o,
    output logic [6:0]       w_addr_o,
    output logic [31:0]      w_dt_o,
    output logic             wave_we_o,
    output logic [167:0]     wave_dt_o,
    output logic             err_ro_o
);

    localparam int unsigned   CW      = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_SEC  = 2'd2,
        GNT_WAVE = 2'd3
    } gnt_kind_t;

    gnt_kind_t          gnt_kind_s;
    logic [1:0]         sec_idx_s;
    logic [2:0]         starved_s;
    logic               wave_hazard_s;
    logic [6:0]         wr_addr_s;
    logic [31:0]        wr_dt_s;
    logic [2:0][CW-1:0] cnt_r;
    logic [1:0]         ptr_r;
    logic               we_r;
    logic [6:0]         w_addr_r;
    logic [31:0]        w_dt_r;
    logic               wave_we_r;
    logic [167:0]       wave_dt_r;
    logic               err_r;

    // Read-only specials: 0x42..0x4B and the whole 0x60..0x7F window.
    function automatic logic is_ro(input logic [6:0] addr);
        logic ro;
        if ((addr >= 7'h42) && (addr <= 7'h4B)) ro = 1'b1;
        else if (addr[6:5] == 2'b11)            ro = 1'b1;
        else                                    ro = 1'b0;
        return ro;
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // Walk the search order backwards so the first valid index from the pointer wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] vld);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = 2'd0;
        idx  = next_idx(next_idx(ptr));
        for (int i = 0; i < 3; i++) begin
            if (vld[idx]) pick = idx;
            else          pick = pick;
            idx = (idx == 2'd0) ? 2'd2 : idx - 2'd1;
        end
        return pick;
    endfunction

    // Starvation flags and the wave-order hazard against the write now on the bank port.
    always_comb begin
        starved_s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            starved_s[k] = req_vld_i[k] && (cnt_r[k] == CNT_MAX);
        end
        wave_hazard_s = we_r && (w_addr_r[6:5] == 2'b01);
    end

    // Single-grant priority: forced secondary > core > round-robin secondary > wave.
    always_comb begin
        gnt_kind_s = GNT_NONE;
        sec_idx_s  = 2'd0;
        if (clear_i) begin
            gnt_kind_s = GNT_NONE;
        end else if (|starved_s) begin
            gnt_kind_s = GNT_SEC;
            if (starved_s[0])      sec_idx_s = 2'd0;
            else if (starved_s[1]) sec_idx_s = 2'd1;
            else                   sec_idx_s = 2'd2;
        end else if (core_we_i) begin
            gnt_kind_s = GNT_CORE;
        end else if (|req_vld_i) begin
            gnt_kind_s = GNT_SEC;
            sec_idx_s  = rr_pick(ptr_r, req_vld_i);
        end else if (wave_vld_i && !wave_hazard_s) begin
            gnt_kind_s = GNT_WAVE;
        end else begin
            gnt_kind_s = GNT_NONE;
        end
    end

    // Mux of the granted single-word write and the combinational handshakes.
    always_comb begin
        wr_addr_s = 7'h00;
        wr_dt_s   = 32'h0000_0000;
        case (gnt_kind_s)
            GNT_CORE: begin
                wr_addr_s = core_addr_i;
                wr_dt_s   = core_dt_i;
            end
            GNT_SEC: begin
                wr_addr_s = req_addr_i[sec_idx_s];
                wr_dt_s   = req_dt_i[sec_idx_s];
            end
            default: begin
                wr_addr_s = 7'h00;
                wr_dt_s   = 32'h0000_0000;
            end
        endcase
        req_rdy_o    = (gnt_kind_s == GNT_SEC) ? (3'b001 << sec_idx_s) : 3'b000;
        wave_rdy_o   = (gnt_kind_s == GNT_WAVE);
        core_stall_o = !clear_i && (|starved_s);
    end

    // Starvation counters and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= '0;
            ptr_r <= 2'd0;
        end else if (clear_i) begin
            cnt_r <= '0;
            ptr_r <= 2'd0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!req_vld_i[k] || ((gnt_kind_s == GNT_SEC) && (sec_idx_s == 2'(k))))
                    cnt_r[k] <= '0;
                else if (cnt_r[k] != CNT_MAX)
                    cnt_r[k] <= cnt_r[k] + CW'(1);
                else
                    cnt_r[k] <= cnt_r[k];
            end
            if (gnt_kind_s == GNT_SEC) ptr_r <= next_idx(sec_idx_s);
            else                       ptr_r <= ptr_r;
        end
    end

    // Registered bank ports; dropped read-only writes leave address/data untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_r      <= 1'b0;
            w_addr_r  <= 7'h00;
            w_dt_r    <= 32'h0000_0000;
            wave_we_r <= 1'b0;
            wave_dt_r <= '0;
            err_r     <= 1'b0;
        end else if (clear_i) begin
            we_r      <= 1'b0;
            wave_we_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            we_r      <= 1'b0;
            wave_we_r <= 1'b0;
            err_r     <= 1'b0;
            case (gnt_kind_s)
                GNT_CORE, GNT_SEC: begin
                    if (is_ro(wr_addr_s)) begin
                        err_r <= 1'b1;
                    end else begin
                        we_r     <= 1'b1;
                        w_addr_r <= wr_addr_s;
                        w_dt_r   <= wr_dt_s;
                    end
                end
                GNT_WAVE: begin
                    wave_we_r <= 1'b1;
                    wave_dt_r <= wave_dt_i;
                end
                default: begin
                    we_r <= 1'b0;
                end
            endcase
        end
    end

    assign we_o      = we_r;
    assign w_addr_o  = w_addr_r;
    assign w_dt_o    = w_dt_r;
    assign wave_we_o = wave_we_r;
    assign wave_dt_o = wave_dt_r;
    assign err_ro_o  = err_r;

endmodule
